pragmatic_seq_pe: RTL and testbench
===================================

Name: pragmatic_seq_pe

Overview:
- Next-generation Pragmatic-style processing element for essential-bit activation×weight dot products.
- Replaces externally supplied per-lane shift selects with an internal one-offset sequencer. Each lane's weight magnitude is walked MSB-first, one set bit per cycle per lane.
- Per vector, the PE issues max-popcount cycles, accumulates across vectors until `in_last`, then presents the dot product on a valid/ready output.
- Sits between the activation/weight buffers and the output collector in the BitSim array.

Parameters:
- `DATA_WIDTH`, 8: signed activation and weight width.
- `VEC_LENGTH`, 16: lanes per vector; power of two, ≥2.
- `ACC_WIDTH`, `2*DATA_WIDTH+8`: accumulator and result width; must be ≥ `2*DATA_WIDTH+$clog2(VEC_LENGTH)`.
- `CNT_WIDTH`, 16: width of the run-cycle statistics counter.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: input vector valid.
- `in_ready`, out, 1: PE accepts a vector.
- `in_last`, in, 1: vector closes the current dot product.
- `act_in`, in, `[DATA_WIDTH-1:0]` x `VEC_LENGTH`, signed: activations.
- `wgt_in`, in, `[DATA_WIDTH-1:0]` x `VEC_LENGTH`, signed: weights.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer takes result.
- `result`, out, `[ACC_WIDTH-1:0]`, signed: completed dot product.
- `run_cycles`, out, `[CNT_WIDTH-1:0]`: RUN cycles spent on the dot product in `result`.

Behaviour:
- Reset (async assert, sync deassert on `clk`):
  - state=IDLE; all registers zero.
  - `in_ready`=1, `out_valid`=0, `result`=0, `run_cycles`=0.
- FSM states IDLE, RUN, OUT.
  - `in_ready`=1 only in IDLE.
  - `out_valid`=1 only in OUT.
- Accept on `in_valid && in_ready`:
  - Per lane, latch `act_in` sign-extended to `ACC_WIDTH`.
  - Latch `mag=|wgt_in|` as unsigned `DATA_WIDTH` bits (−2^(DW−1) → 2^(DW−1), no overflow).
  - Latch `neg=wgt_in[DW−1]` and `last=in_last`.
  - Next state RUN.
- Each RUN cycle, per lane:
  - `p` = index of the highest set bit of `mag`.
  - `term` = act<<<p, two's-complement negated if `neg`; 0 if `mag`==0.
  - Clear bit `p` of `mag`.
- Adder tree sums all lanes combinationally.
  - `acc <= acc + sum`, wrapping modulo 2^`ACC_WIDTH` (no saturation).
  - Run counter increments by 1, saturating at all-ones.
- RUN exit when every lane's post-clear `mag` is 0:
  - `last`=1 → OUT; `result` register ← final `acc`; `run_cycles` ← final counter; `acc` and counter cleared.
  - `last`=0 → IDLE, `acc` retained.
- All-zero weights: exactly 1 RUN cycle, adding 0.
- RUN length per vector = max(1, max lane popcount(|w|)).
- Accept-to-`out_valid` latency = RUN length + 1 cycles.
- Handshakes:
  - OUT: `result`/`run_cycles` held stable while `out_ready`=0; `in_ready` stays 0 (back-pressure propagates).
  - `out_valid && out_ready` → IDLE next cycle.
  - A new vector is accepted no earlier than the cycle after the output handshake.
- `in_valid` with `in_ready`=0 is ignored; the upstream source must hold its data.
- `in_last` is sampled only at accept.
- Reset asserted mid-RUN or mid-OUT:
  - Partial accumulation is discarded.
  - Outputs return to reset values immediately, without waiting for a clock edge.
- `result`, `run_cycles` and `out_valid` are driven from registers, with no combinational path from inputs.

Test Plan:
- Unless stated otherwise, VL=4, DW=8, ACC=24.
- act={1,2,3,4}, w={1,1,1,1}, last=1 → 1 RUN cycle; `out_valid` 2 cycles after accept; `result`=10, `run_cycles`=1.
- act={2,0,0,0}, w={127,0,0,0}, last=1 → 7 RUN cycles; `result`=254, `run_cycles`=7; `in_ready`=0 for 8 cycles after accept.
- act={−128,0,0,0}, w={−128,0,0,0} → `result`=16384, 1 cycle. Repeat with act=−128, w=127 → −16256.
- Vector A act={1,1,1,1}, w={3,3,3,3}, last=0, then vector B act={2,2,2,2}, w={−1,−1,−1,−1}, last=1 → `result`=4, `run_cycles`=3; no `out_valid` between the vectors.
- Hold `out_ready`=0 for 5 cycles in OUT with `in_valid`=1 → `result` stable, `in_ready`=0 throughout; on `out_ready`=1, IDLE next cycle, then the new vector is accepted.
- Assert `reset` asynchronously during RUN of w={127,…} → `out_valid`=0 and `in_ready`=1 immediately. Next dot product act={1,1,1,1}, w={1,1,1,1} → `result`=4, with no residue from the aborted run.

Source files
------------

// File: rtl/pragmatic_seq_pe.sv
// Pragmatic-style essential-bit PE. Each lane's weight magnitude is walked MSB-first, one set bit per cycle.
// Partial sums accumulate across vectors until the last vector, then the dot product is offered on valid/ready.
module pragmatic_seq_pe #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 16,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    input  logic signed [DATA_WIDTH-1:0] act_in [VEC_LENGTH],
    input  logic signed [DATA_WIDTH-1:0] wgt_in [VEC_LENGTH],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_WIDTH-1:0]  result,
    output logic [CNT_WIDTH-1:0]         run_cycles
);

    localparam int PW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t                       state;
    logic signed [ACC_WIDTH-1:0]  act_q    [VEC_LENGTH];
    logic [DATA_WIDTH-1:0]        mag_q    [VEC_LENGTH];
    logic                         neg_q    [VEC_LENGTH];
    logic                         last_q;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic [CNT_WIDTH-1:0]         run_cnt;

    logic [PW-1:0]                msb_idx  [VEC_LENGTH];
    logic signed [ACC_WIDTH-1:0]  shifted  [VEC_LENGTH];
    logic signed [ACC_WIDTH-1:0]  term     [VEC_LENGTH];
    logic [DATA_WIDTH-1:0]        mag_next [VEC_LENGTH];
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic [CNT_WIDTH-1:0]         cnt_next;
    logic                         all_clear;

    function automatic logic [PW-1:0] msb_index(input logic [DATA_WIDTH-1:0] m);
        msb_index = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            if (m[b]) msb_index = PW'(b);
        end
    endfunction

    // One essential bit per lane per cycle, summed by a flat adder tree.
    always_comb begin
        sum       = '0;
        all_clear = 1'b1;
        for (int i = 0; i < VEC_LENGTH; i++) begin
            msb_idx[i]  = msb_index(mag_q[i]);
            shifted[i]  = act_q[i] <<< msb_idx[i];
            term[i]     = '0;
            if (mag_q[i] != '0) term[i] = neg_q[i] ? -shifted[i] : shifted[i];
            mag_next[i] = mag_q[i] & ~(DATA_WIDTH'(1) << msb_idx[i]);
            if (mag_next[i] != '0) all_clear = 1'b0;
            sum = sum + term[i];
        end
        acc_next = acc + sum;
        cnt_next = (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            result     <= '0;
            run_cycles <= '0;
            acc        <= '0;
            run_cnt    <= '0;
            last_q     <= 1'b0;
            for (int i = 0; i < VEC_LENGTH; i++) begin
                act_q[i] <= '0;
                mag_q[i] <= '0;
                neg_q[i] <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < VEC_LENGTH; i++) begin
                            act_q[i] <= {{(ACC_WIDTH-DATA_WIDTH){act_in[i][DATA_WIDTH-1]}}, act_in[i]};
                            // Negating -2^(DW-1) wraps back to the same bits, which read as 2^(DW-1) unsigned.
                            mag_q[i] <= wgt_in[i][DATA_WIDTH-1] ? DATA_WIDTH'(-wgt_in[i])
                                                                : DATA_WIDTH'(wgt_in[i]);
                            neg_q[i] <= wgt_in[i][DATA_WIDTH-1];
                        end
                        last_q   <= in_last;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc     <= acc_next;
                    run_cnt <= cnt_next;
                    for (int i = 0; i < VEC_LENGTH; i++) mag_q[i] <= mag_next[i];
                    if (all_clear) begin
                        if (last_q) begin
                            result     <= acc_next;
                            run_cycles <= cnt_next;
                            acc        <= '0;
                            run_cnt    <= '0;
                            out_valid  <= 1'b1;
                            state      <= OUT;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pragmatic_seq_pe.sv
// Bench for pragmatic_seq_pe: a dot-product/popcount model checked every cycle, plus directed vectors
// with literal expected results.
module tb_pragmatic_seq_pe;

    localparam int DW = 8;
    localparam int VL = 4;
    localparam int AW = 24;
    localparam int CW = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic signed [DW-1:0]  act_in [VL];
    logic signed [DW-1:0]  wgt_in [VL];
    logic                  out_valid;
    logic                  out_ready;
    logic signed [AW-1:0]  result;
    logic [CW-1:0]         run_cycles;

    int checks = 0;
    int passed = 0;

    pragmatic_seq_pe #(
        .DATA_WIDTH(DW), .VEC_LENGTH(VL), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .act_in(act_in), .wgt_in(wgt_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("[TB] FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    endtask

    // Model: a vector costs max(1, max popcount|w|) busy cycles and adds sum(a*w) to the running dot product.
    int                   busy = 0;
    bit                   outp = 1'b0;
    bit                   pend_last = 1'b0;
    logic signed [AW-1:0] acc_m = '0;
    logic signed [AW-1:0] exp_result = '0;
    logic [CW-1:0]        exp_run = '0;
    int                   cyc_m = 0;
    int                   dot, len, pc, av;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy = 0; outp = 1'b0; pend_last = 1'b0;
            acc_m = '0; cyc_m = 0; exp_result = '0; exp_run = '0;
        end else if (outp) begin
            if (out_ready) outp = 1'b0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0 && pend_last) begin
                outp       = 1'b1;
                exp_result = acc_m;
                exp_run    = (cyc_m > 65535) ? 16'hFFFF : CW'(cyc_m);
                acc_m      = '0;
                cyc_m      = 0;
            end
        end else if (in_valid) begin
            dot = 0;
            len = 0;
            for (int i = 0; i < VL; i++) begin
                dot += int'(act_in[i]) * int'(wgt_in[i]);
                av = int'(wgt_in[i]);
                if (av < 0) av = -av;
                pc = $countones(av);
                if (pc > len) len = pc;
            end
            if (len == 0) len = 1;
            acc_m     = acc_m + AW'(dot);
            cyc_m    += len;
            busy      = len;
            pend_last = in_last;
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_ready, (busy == 0 && !outp));
        check("out_valid", out_valid, outp);
        check("result", result, exp_result);
        check("run_cycles", run_cycles, exp_run);
    end

    task automatic apply_stimulus(input int a0, a1, a2, a3, w0, w1, w2, w3, input logic last);
        int n = 0;
        act_in[0] = DW'(a0); act_in[1] = DW'(a1); act_in[2] = DW'(a2); act_in[3] = DW'(a3);
        wgt_in[0] = DW'(w0); wgt_in[1] = DW'(w1); wgt_in[2] = DW'(w2); wgt_in[3] = DW'(w3);
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait", (n < 100), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Walks from just after the accept edge until in_ready returns, capturing the first result offered.
    task automatic check_output(input string name, input logic expect_out, input int exp_res,
                                input int exp_rc, input int exp_lat, input int exp_busy);
        int n = 0;
        int lat = 0;
        bit seen = 1'b0;
        logic [AW-1:0] got_res = '0;
        logic [CW-1:0] got_run = '0;
        while (!in_ready && n < 300) begin
            if (out_valid && !seen) begin
                seen    = 1'b1;
                lat     = n + 1;
                got_res = result;
                got_run = run_cycles;
            end
            n++;
            @(posedge clk); #1;
        end
        check({name, "_seen"}, seen, expect_out);
        check({name, "_busy"}, n, exp_busy);
        if (expect_out) begin
            check({name, "_result"}, $signed(got_res), exp_res);
            check({name, "_runcyc"}, got_run, exp_rc);
            check({name, "_latency"}, lat, exp_lat);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < VL; i++) begin act_in[i] = '0; wgt_in[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_run_cycles", run_cycles, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        apply_stimulus(1, 2, 3, 4, 1, 1, 1, 1, 1'b1);
        check_output("basic", 1'b1, 10, 1, 2, 2);

        apply_stimulus(5, 5, 5, 5, 0, 0, 0, 0, 1'b1);
        check_output("zero_wgt", 1'b1, 0, 1, 2, 2);

        apply_stimulus(2, 0, 0, 0, 127, 0, 0, 0, 1'b1);
        check_output("w127", 1'b1, 254, 7, 8, 8);

        apply_stimulus(-128, 0, 0, 0, -128, 0, 0, 0, 1'b1);
        check_output("min_min", 1'b1, 16384, 1, 2, 2);

        apply_stimulus(-128, 0, 0, 0, 127, 0, 0, 0, 1'b1);
        check_output("min_max", 1'b1, -16256, 7, 8, 8);

        apply_stimulus(1, 1, 1, 1, 3, 3, 3, 3, 1'b0);
        check_output("vec_a", 1'b0, 0, 0, 0, 2);
        apply_stimulus(2, 2, 2, 2, -1, -1, -1, -1, 1'b1);
        check_output("vec_b", 1'b1, 4, 3, 2, 2);

        // Back-pressure: consumer stalls while the next vector is already waiting.
        out_ready = 1'b0;
        apply_stimulus(1, 2, 3, 4, 1, 1, 1, 1, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("bp_reach_out", (n < 50), 1);
        for (int i = 0; i < VL; i++) begin act_in[i] = 8'sd1; wgt_in[i] = 8'sd2; end
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_result", result, 10);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_valid", out_valid, 0);
        check("bp_idle_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accepted", in_ready, 0);
        check_output("bp_next", 1'b1, 8, 1, 2, 2);

        // Asynchronous reset in the middle of a long run.
        apply_stimulus(2, 0, 0, 0, 127, 0, 0, 0, 1'b1);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_result", result, 0);
        check("arst_run_cycles", run_cycles, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        apply_stimulus(1, 1, 1, 1, 1, 1, 1, 1, 1'b1);
        check_output("post_reset", 1'b1, 4, 1, 2, 2);

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
